// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder: default slice width, stage
// count helper and the per-stage control record.
package adder_pkg;

    localparam int DEFAULT_CHUNK = 4;

    // Number of pipeline stages for a WIDTH-bit add split into CHUNK-bit slices.
    function automatic int stages(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Per-stage control bits. The data part of a lane (partial sum, upper
    // operand bits) changes width from stage to stage, so it is held next to
    // this record inside each stage rather than in a fixed-width struct.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

endpackage

// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle for adder_pipe.
// The sat signal exists only when ADDER_PIPE_SAT_EN is defined.
interface adder_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef ADDER_PIPE_SAT_EN
    logic             sat;

    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout, sat);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout, sat);
`else
    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple-carry adder built from half-adder pairs.
module adder_chunk
    import adder_pkg::*;
#(
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        logic s1, c1, c2;
        half_adder u_ha0 (.a(a[i]), .b(b[i]), .s(s1),     .c(c1));
        half_adder u_ha1 (.a(s1),   .b(c[i]), .s(sum[i]), .c(c2));
        assign c[i+1] = c1 | c2;
    end

    assign cout = c[CHUNK];
endmodule

// File: rtl/half_adder.sv
// Single-bit half adder cell; two of these plus an OR make a full adder.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/adder_pipe.sv
// Pipelined unsigned adder: {cout, sum} = a + b + cin, one CHUNK-bit slice
// resolved per stage with the carry registered between stages.
// Whole pipeline advances together when the output slot is free or drained.
// Optional macro ADDER_PIPE_SAT_EN: clamp sum to all ones on carry-out and
// raise sat; cout still reports the raw carry.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic       clk,
    input  logic       rst_n,
    adder_pipe_if.slave bus
);
    localparam int STAGES = stages(WIDTH, CHUNK);

    logic advance;
    logic in_fire;
    logic last_valid;

    assign advance      = !last_valid || bus.out_ready;
    assign bus.in_ready = advance;
    assign in_fire      = bus.in_valid && advance;
    assign bus.out_valid = last_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be added when entering this stage.
        localparam int SRC_W = WIDTH - k * CHUNK;
        // Sum bits resolved once this stage has registered.
        localparam int LO_W  = (k + 1) * CHUNK;

        logic [SRC_W-1:0] src_a, src_b;
        logic             src_valid, src_carry;
        logic [CHUNK-1:0] part;
        logic             carry;
        logic [LO_W-1:0]  s_next, s_load;
        logic [LO_W-1:0]  s_lo;
        stage_ctl_t       ctl_q;

        if (k == 0) begin : g_src
            assign src_a     = bus.a;
            assign src_b     = bus.b;
            assign src_valid = in_fire;
            assign src_carry = bus.cin;
            assign s_next    = part;
        end else begin : g_src
            assign src_a     = g_stage[k-1].g_hi.a_hi;
            assign src_b     = g_stage[k-1].g_hi.b_hi;
            assign src_valid = g_stage[k-1].ctl_q.valid;
            assign src_carry = g_stage[k-1].ctl_q.carry;
            assign s_next    = {part, g_stage[k-1].s_lo};
        end

        adder_chunk #(.CHUNK(CHUNK)) u_add (
            .a    (src_a[CHUNK-1:0]),
            .b    (src_b[CHUNK-1:0]),
            .cin  (src_carry),
            .sum  (part),
            .cout (carry)
        );

        // Stage register: valid, carry and the sum bits produced so far.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ctl_q <= '0;
                s_lo  <= '0;
            end else if (advance) begin
                ctl_q.valid <= src_valid;
                ctl_q.carry <= carry;
                s_lo        <= s_load;
            end
        end

        if (k < STAGES - 1) begin : g_hi
            logic [SRC_W-CHUNK-1:0] a_hi, b_hi;

            // Carry the not-yet-added operand bits to the next stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_hi <= '0;
                    b_hi <= '0;
                end else if (advance) begin
                    a_hi <= src_a[SRC_W-1:CHUNK];
                    b_hi <= src_b[SRC_W-1:CHUNK];
                end
            end

            assign s_load = s_next;
        end else begin : g_out
`ifdef ADDER_PIPE_SAT_EN
            logic sat_q;

            assign s_load = carry ? '1 : s_next;

            // Saturation flag travels with the clamped result.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)       sat_q <= 1'b0;
                else if (advance) sat_q <= carry;
            end

            assign bus.sat = sat_q;
`else
            assign s_load = s_next;
`endif
            assign bus.sum    = s_lo;
            assign bus.cout   = ctl_q.carry;
            assign last_valid = ctl_q.valid;
        end
    end
endmodule
